// File: rtl/spi_master_controller.sv
// SPI master: serialises 10-bit RAM commands onto SS_n/MOSI and captures read words from MISO.
// Latency: 15 cycles accept-to-ready for write/rd-addr frames, 24 for rd-data frames (defaults).
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while a frame is in flight.
module spi_master_controller #(
  parameter int CMD_WIDTH   = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int RD_LATENCY  = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CMD_WIDTH-1:0]  cmd_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  seq_err,
  output logic                  busy,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  // One shared down-counter serves every timed state; size it for the longest one.
  localparam int M1      = (CMD_WIDTH > DATA_WIDTH) ? CMD_WIDTH : DATA_WIDTH;
  localparam int M2      = (HOLD_CYCLES > RD_LATENCY) ? HOLD_CYCLES : RD_LATENCY;
  localparam int M3      = (M1 > M2) ? M1 : M2;
  localparam int CNT_MAX = (M3 > GAP_CYCLES) ? M3 : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int IDX_W   = (CMD_WIDTH < 2) ? 1 : $clog2(CMD_WIDTH);

  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_CMD, S_SHIFT, S_HOLD, S_WAIT_RD, S_CAPTURE, S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  seq_err_q, seq_err_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_frame_q, rd_frame_d;
  logic                  ss_n_q, ss_n_d;
  logic                  mosi_q, mosi_d;
  logic [IDX_W-1:0]      bit_idx;
  logic                  cnt_last;
  logic [1:0]            opcode;

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign seq_err   = seq_err_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign cnt_last  = (cnt_q == '0);
  assign opcode    = cmd_data[CMD_WIDTH-1 -: 2];

  // Next-state, counter reloads, read tracking and the pin values for the next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    seq_err_d  = 1'b0;
    rd_pend_d  = rd_pend_q;
    rd_frame_d = rd_frame_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d    = S_START;
          cmd_d      = cmd_data;
          rd_frame_d = 1'b0;
          if (opcode == OP_RD_ADDR) begin
            rd_pend_d = 1'b1;
          end else if (opcode == OP_RD_DATA) begin
            // With nothing pending the slave takes this frame as a read address.
            if (rd_pend_q) begin
              rd_frame_d = 1'b1;
              rd_pend_d  = 1'b0;
            end else begin
              seq_err_d  = 1'b1;
              rd_pend_d  = 1'b1;
            end
          end
        end
      end
      S_START: state_d = S_CMD;
      S_CMD: begin
        state_d = S_SHIFT;
        cnt_d   = CNT_W'(CMD_WIDTH - 1);
      end
      S_SHIFT: begin
        if (!cnt_last) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rd_frame_q) begin
          state_d = S_WAIT_RD;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
        end else begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      S_HOLD, S_WAIT_RD: begin
        if (!cnt_last) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == S_HOLD) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          state_d = S_CAPTURE;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
        end
      end
      S_CAPTURE: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], MISO};
        if (!cnt_last) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d    = S_GAP;
          cnt_d      = CNT_W'(GAP_CYCLES - 1);
          rd_data_d  = shift_d;
          rd_valid_d = 1'b1;
        end
      end
      S_GAP: begin
        if (!cnt_last) cnt_d = cnt_q - CNT_W'(1);
        else           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are registered, so they are decoded from the state being entered.
    bit_idx = cnt_d[IDX_W-1:0];
    ss_n_d  = (state_d == S_IDLE) || (state_d == S_GAP);
    mosi_d  = 1'b0;
    if (state_d == S_CMD)        mosi_d = cmd_d[CMD_WIDTH-1];
    else if (state_d == S_SHIFT) mosi_d = cmd_q[bit_idx];
  end

  // State and datapath registers; reset drops the frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      shift_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_frame_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      seq_err_q  <= seq_err_d;
      rd_pend_q  <= rd_pend_d;
      rd_frame_q <= rd_frame_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

endmodule
